// File: rtl/count_dec_pkg.sv
// Shared constants and code conversion for the count direction decoder.
// GRAY_DECODE_EN selects Gray/quadrature decoding of the accepted code.
package count_dec_pkg;

   localparam logic [1:0] DELTA_NONE = 2'd0;
   localparam logic [1:0] DELTA_UP   = 2'd1;
   localparam logic [1:0] DELTA_SKIP = 2'd2;
   localparam logic [1:0] DELTA_DOWN = 2'd3;

   localparam int UIO_DIR   = 0;
   localparam int UIO_STEP  = 1;
   localparam int UIO_ERR   = 2;
   localparam int UIO_VALID = 3;

   localparam logic [7:0] UIO_OE_VAL = 8'h0F;

   // Map an accepted 2-bit code onto the binary counting order
   function automatic logic [1:0] to_bin(input logic [1:0] c);
`ifdef GRAY_DECODE_EN
      return {c[1], c[1] ^ c[0]};
`else
      return c;
`endif
   endfunction

endpackage

// File: rtl/code_glitch_filter.sv
// Two-flop synchronizer followed by a stability filter on a 2-bit code.
// Emits a single-cycle accept strobe once a code has held FILT_CYCLES edges.
module code_glitch_filter #(
   parameter int FILT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] code,
   output logic       accept,
   output logic [1:0] accepted_code
);

   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] sync_vld;
   logic [1:0] cand;
   logic       cand_vld;
   logic [3:0] cnt;
   logic       differs;

   // The valid pipeline keeps post-reset flop contents from counting as a sampled code
   assign differs       = !cand_vld || (sync2 != cand);
   assign accepted_code = sync2;

   always_comb begin
      accept = 1'b0;
      if (sync_vld[1]) begin
         if (differs) accept = (FILT_CYCLES == 1);
         else         accept = (cnt == 4'(FILT_CYCLES - 1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= 2'b00;
         sync2    <= 2'b00;
         sync_vld <= 2'b00;
         cand     <= 2'b00;
         cand_vld <= 1'b0;
         cnt      <= 4'd0;
      end else begin
         sync1    <= code;
         sync2    <= sync1;
         sync_vld <= {sync_vld[0], 1'b1};
         if (sync_vld[1]) begin
            if (differs) begin
               cand     <= sync2;
               cand_vld <= 1'b1;
               cnt      <= 4'd1;
            end else if (cnt < 4'(FILT_CYCLES)) begin
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/tt_um_count_direction_decoder.sv
// Tiny Tapeout tile decoding a 2-bit up/down count stream into a signed position.
// Build with GRAY_DECODE_EN defined to decode Gray/quadrature codes instead of binary.
module tt_um_count_direction_decoder
   import count_dec_pkg::*;
#(
   parameter int FILT_CYCLES = 2,
   parameter int POS_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic             accept;
   logic [1:0]       acc_code;
   logic [1:0]       reference;
   logic [1:0]       delta;
   logic [POS_W-1:0] position;
   logic             dir;
   logic             step;
   logic             err;
   logic             valid;
   logic             clear;
   logic             unused_ok;

   assign clear     = ui_in[2];
   assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

   code_glitch_filter #(
      .FILT_CYCLES(FILT_CYCLES)
   ) u_filter (
      .clk          (clk),
      .rst_n        (rst_n),
      .code         (ui_in[1:0]),
      .accept       (accept),
      .accepted_code(acc_code)
   );

   assign delta = to_bin(acc_code) - to_bin(reference);

   // Clear is applied last so it overrides any step taken on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reference <= 2'b00;
         position  <= '0;
         dir       <= 1'b0;
         step      <= 1'b0;
         err       <= 1'b0;
         valid     <= 1'b0;
      end else begin
         step <= 1'b0;
         if (accept) begin
            reference <= acc_code;
            if (!valid) begin
               valid <= 1'b1;
            end else begin
               case (delta)
                  DELTA_UP: begin
                     position <= position + POS_W'(1);
                     dir      <= 1'b1;
                     step     <= 1'b1;
                  end
                  DELTA_DOWN: begin
                     position <= position - POS_W'(1);
                     dir      <= 1'b0;
                     step     <= 1'b1;
                  end
                  DELTA_SKIP: err <= 1'b1;
                  DELTA_NONE: ;
                  default: ;
               endcase
            end
         end
         if (clear) begin
            position <= '0;
            err      <= 1'b0;
            step     <= 1'b0;
         end
      end
   end

   always_comb begin
      uio_out            = 8'h00;
      uio_out[UIO_DIR]   = dir;
      uio_out[UIO_STEP]  = step;
      uio_out[UIO_ERR]   = err;
      uio_out[UIO_VALID] = valid;
   end

   assign uo_out = position[7:0];
   assign uio_oe = UIO_OE_VAL;

endmodule
